// File: rtl/grid_ascii_loader_if.sv
// Byte-in / grid-out bundle for grid_ascii_loader. The byte source and the grid consumer
// drive through the master modport; the loader takes the slave side.
interface grid_ascii_loader_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(WIDTH * DEPTH + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               in_data;
  logic                     in_last;
  logic [WIDTH*DEPTH-1:0]   grid;
  logic [RW-1:0]            rows;
  logic [CW-1:0]            cols;
  logic [NW-1:0]            rolls;
  logic                     grid_valid;
  logic                     grid_ack;
  logic                     err;
  logic [1:0]               err_code;

  modport master (
    output in_valid, in_data, in_last, grid_ack,
    input  in_ready, grid, rows, cols, rolls, grid_valid, err, err_code
  );

  modport slave (
    input  in_valid, in_data, in_last, grid_ack,
    output in_ready, grid, rows, cols, rolls, grid_valid, err, err_code
  );
endinterface

// File: rtl/grid_ascii_loader.sv
// Parses an ASCII puzzle ('@' roll, '.' empty, '\n' row end) into a flattened bit matrix,
// checks the grid shape and holds the finished grid until the consumer acknowledges it.
module grid_ascii_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  grid_ascii_loader_if.slave bus
);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(WIDTH * DEPTH + 1);
  localparam int GW = WIDTH * DEPTH;
  localparam int IW = (GW > 1) ? $clog2(GW) : 1;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [RW-1:0] DEPTH_C = RW'(DEPTH);

  logic [1:0]    state_q,    state_d;
  logic [GW-1:0] grid_q,     grid_d;
  logic [RW-1:0] rows_q,     rows_d;
  logic [CW-1:0] cols_q,     cols_d;
  logic [NW-1:0] rolls_q,    rolls_d;
  logic [CW-1:0] col_cnt_q,  col_cnt_d;
  logic [1:0]    err_code_q, err_code_d;
  // Set when the byte that raised the error also ended the frame: nothing left to drain.
  logic          err_exit_q, err_exit_d;

  logic          in_ready;
  logic          fire;
  logic          is_cell;
  logic          is_lf;
  logic          err_hit;
  logic          done_hit;
  logic          close_row;
  logic          clear_all;
  logic [1:0]    code;
  logic [IW-1:0] cell_idx;

  assign in_ready = (state_q == S_FILL) || (state_q == S_ERR);
  assign fire     = bus.in_valid && in_ready;
  assign is_cell  = (bus.in_data == CH_ROLL) || (bus.in_data == CH_EMPTY);
  assign is_lf    = (bus.in_data == CH_LF);
  assign cell_idx = IW'(int'(rows_q) * WIDTH + int'(col_cnt_q));

  always_comb begin : next_state
    // NOTE: every _d and temporary takes a default first, so no path through this block infers a latch.
    state_d    = state_q;
    grid_d     = grid_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    rolls_d    = rolls_q;
    col_cnt_d  = col_cnt_q;
    err_code_d = err_code_q;
    err_exit_d = err_exit_q;
    err_hit    = 1'b0;
    done_hit   = 1'b0;
    close_row  = 1'b0;
    clear_all  = 1'b0;
    code       = 2'd0;

    case (state_q)
      S_FILL: begin
        if (fire) begin
          if (is_cell) begin
            if (col_cnt_q == WIDTH_C || rows_q == DEPTH_C) begin
              err_hit = 1'b1;
              code    = 2'd1;
            end else begin
              grid_d[cell_idx] = (bus.in_data == CH_ROLL);
              col_cnt_d        = col_cnt_q + CW'(1);
              if (bus.in_data == CH_ROLL) rolls_d = rolls_q + NW'(1);
            end
          end else if (is_lf) begin
            if (col_cnt_q == '0 && rows_q != '0) done_hit = 1'b1;
          end else if (bus.in_data != CH_CR) begin
            err_hit = 1'b1;
            code    = 2'd0;
          end

          // A row closes on '\n', or on the frame's last byte if it left a partial row open.
          close_row = !err_hit && (col_cnt_d != '0) && (is_lf || bus.in_last);
          if (close_row) begin
            if (rows_q != '0 && col_cnt_d != cols_q) begin
              err_hit = 1'b1;
              code    = 2'd2;
            end else begin
              if (rows_q == '0) cols_d = col_cnt_d;
              rows_d    = rows_q + RW'(1);
              col_cnt_d = '0;
            end
          end

          if (err_hit) begin
            state_d    = S_ERR;
            err_code_d = code;
            err_exit_d = bus.in_last;
          end else if (done_hit || bus.in_last) begin
            if (rows_d == '0) begin
              state_d    = S_ERR;
              err_code_d = 2'd3;
              err_exit_d = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  if (bus.grid_ack) clear_all = 1'b1;
      S_ERR:   if (err_exit_q || (fire && bus.in_last)) clear_all = 1'b1;
      default: clear_all = 1'b1;
    endcase

    if (clear_all) begin
      state_d    = S_FILL;
      grid_d     = '0;
      rows_d     = '0;
      cols_d     = '0;
      rolls_d    = '0;
      col_cnt_d  = '0;
      err_code_d = 2'd0;
      err_exit_d = 1'b0;
    end
  end

  // NOTE: the grid is a flop vector read in parallel by the evaluators, not a RAM, so it takes reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      grid_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      rolls_q    <= '0;
      col_cnt_q  <= '0;
      err_code_q <= 2'd0;
      err_exit_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      grid_q     <= grid_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      rolls_q    <= rolls_d;
      col_cnt_q  <= col_cnt_d;
      err_code_q <= err_code_d;
      err_exit_q <= err_exit_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.grid       = grid_q;
  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;
  assign bus.rolls      = rolls_q;
  assign bus.grid_valid = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_grid_ascii_loader.sv
// Self-checking bench for grid_ascii_loader: directed frames plus random grids, each frame's
// expected outcome computed by a line-oriented text model of the puzzle format.
module tb_grid_ascii_loader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int GW    = WIDTH * DEPTH;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int           kind;
    int           pos;
    int           code;
    int           rows;
    int           cols;
    int           rolls;
    logic [GW-1:0] grid;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  grid_ascii_loader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  grid_ascii_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Whole-frame model: splits the text into lines, validates each line as it ends,
  // then builds the matrix from the accepted lines.
  function automatic exp_t model(input string s, input bit last);
    exp_t  e;
    string line;
    string rq[$];
    int    code;
    line    = "";
    e.kind  = K_NONE;
    e.pos   = -1;
    e.code  = 0;
    e.rows  = 0;
    e.cols  = 0;
    e.rolls = 0;
    e.grid  = '0;
    for (int i = 0; i < s.len(); i++) begin
      byte ch;
      bit  fin;
      bit  done;
      ch   = s[i];
      fin  = last && (i == s.len() - 1);
      code = -1;
      done = 1'b0;
      if (ch == "@" || ch == ".") begin
        if (line.len() == WIDTH || rq.size() == DEPTH) code = 1;
        else line = $sformatf("%s%c", line, ch);
      end else if (ch == 8'h0A) begin
        if (line.len() > 0) begin
          if (rq.size() > 0 && line.len() != rq[0].len()) code = 2;
          else begin rq.push_back(line); line = ""; end
        end else if (rq.size() > 0) begin
          done = 1'b1;
        end
      end else if (ch != 8'h0D) begin
        code = 0;
      end
      if (code < 0 && fin) begin
        if (line.len() > 0) begin
          if (rq.size() > 0 && line.len() != rq[0].len()) code = 2;
          else begin rq.push_back(line); line = ""; end
        end
        if (code < 0) begin
          if (rq.size() == 0) code = 3;
          else done = 1'b1;
        end
      end
      if (code >= 0) begin
        e.kind = K_ERR;
        e.pos  = i;
        e.code = code;
        return e;
      end
      if (done) begin
        e.kind = K_DONE;
        e.pos  = i;
        e.rows = rq.size();
        e.cols = rq[0].len();
        for (int r = 0; r < rq.size(); r++)
          for (int c = 0; c < rq[r].len(); c++)
            if (rq[r][c] == "@") begin
              e.grid[r * WIDTH + c] = 1'b1;
              e.rolls++;
            end
        return e;
      end
    end
    return e;
  endfunction

  task automatic push(input byte b, input bit last);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    check("in_ready_fill", GW'(bus.in_ready), GW'(1));
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input string s, input bit last, output exp_t e);
    e = model(s, last);
    for (int i = 0; i < s.len(); i++) begin
      push(s[i], last && (i == s.len() - 1));
      if (e.kind == K_ERR && i == e.pos) begin
        check({tag, "_err"},      GW'(bus.err),      GW'(1));
        check({tag, "_err_code"}, GW'(bus.err_code), GW'(e.code));
      end
      if (e.kind == K_DONE && i == e.pos) break;
    end
    if (e.kind == K_DONE) begin
      check({tag, "_grid_valid"}, GW'(bus.grid_valid), GW'(1));
      check({tag, "_in_ready"},   GW'(bus.in_ready),   GW'(0));
      check({tag, "_err_clr"},    GW'(bus.err),        GW'(0));
      check({tag, "_rows"},       GW'(bus.rows),       GW'(e.rows));
      check({tag, "_cols"},       GW'(bus.cols),       GW'(e.cols));
      check({tag, "_rolls"},      GW'(bus.rolls),      GW'(e.rolls));
      check({tag, "_grid"},       bus.grid,            e.grid);
    end else if (e.kind == K_ERR) begin
      if (e.pos == s.len() - 1) begin
        @(posedge clk);
        #1;
      end
      check({tag, "_err_exit"},  GW'(bus.err),        GW'(0));
      check({tag, "_code_exit"}, GW'(bus.err_code),   GW'(0));
      check({tag, "_rdy_exit"},  GW'(bus.in_ready),   GW'(1));
      check({tag, "_rows_exit"}, GW'(bus.rows),       GW'(0));
      check({tag, "_grid_exit"}, bus.grid,            '0);
    end
  endtask

  // Holds the finished grid for `hold` cycles (optionally offering bytes), then acknowledges it.
  task automatic ack(input string tag, input int hold, input bit with_valid, input exp_t e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.in_valid = with_valid;
      bus.in_data  = 8'h40;
      check({tag, "_hold_ready"}, GW'(bus.in_ready),   GW'(0));
      check({tag, "_hold_valid"}, GW'(bus.grid_valid), GW'(1));
      check({tag, "_hold_rolls"}, GW'(bus.rolls),      GW'(e.rolls));
      check({tag, "_hold_grid"},  bus.grid,            e.grid);
    end
    @(negedge clk);
    bus.grid_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.grid_ack = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_ack_ready"}, GW'(bus.in_ready),   GW'(1));
    check({tag, "_ack_valid"}, GW'(bus.grid_valid), GW'(0));
    check({tag, "_ack_grid"},  bus.grid,            '0);
    check({tag, "_ack_rows"},  GW'(bus.rows),       GW'(0));
    check({tag, "_ack_cols"},  GW'(bus.cols),       GW'(0));
    check({tag, "_ack_rolls"}, GW'(bus.rolls),      GW'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},    GW'(bus.in_ready),   GW'(1));
    check({tag, "_valid"},    GW'(bus.grid_valid), GW'(0));
    check({tag, "_err"},      GW'(bus.err),        GW'(0));
    check({tag, "_err_code"}, GW'(bus.err_code),   GW'(0));
    check({tag, "_rows"},     GW'(bus.rows),       GW'(0));
    check({tag, "_cols"},     GW'(bus.cols),       GW'(0));
    check({tag, "_rolls"},    GW'(bus.rolls),      GW'(0));
    check({tag, "_grid"},     bus.grid,            '0);
  endtask

  initial begin
    exp_t  e;
    string s;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.grid_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Square grid closed by in_last on the final newline.
    run_frame("t1", "@@.\n.@@\n@.@\n", 1'b1, e);
    check("t1_rows_c",  GW'(bus.rows),  GW'(3));
    check("t1_cols_c",  GW'(bus.cols),  GW'(3));
    check("t1_rolls_c", GW'(bus.rolls), GW'(6));
    check("t1_g0",      GW'(bus.grid[0]),         GW'(1));
    check("t1_g2",      GW'(bus.grid[2]),         GW'(0));
    check("t1_gw1",     GW'(bus.grid[WIDTH + 1]), GW'(1));
    ack("t1", 1, 1'b0, e);

    // No trailing newline; grid_ack pulsed while filling must be ignored.
    @(negedge clk);
    bus.grid_ack = 1'b1;
    @(negedge clk);
    bus.grid_ack = 1'b0;
    run_frame("t2", "@.\n@@", 1'b1, e);
    check("t2_rows_c",  GW'(bus.rows),  GW'(2));
    check("t2_cols_c",  GW'(bus.cols),  GW'(2));
    check("t2_rolls_c", GW'(bus.rolls), GW'(3));
    ack("t2", 0, 1'b0, e);

    // Ragged second row, drained by a later in_last byte.
    run_frame("t3", "@@@\n@@\n@.\n", 1'b1, e);

    // Row one cell too wide.
    s = "";
    for (int i = 0; i < WIDTH + 1; i++) s = {s, "@"};
    run_frame("t4w", s, 1'b1, e);
    run_frame("t4c", "@x", 1'b1, e);
    run_frame("t4e", "\n", 1'b1, e);

    // One row too many.
    s = "";
    for (int i = 0; i < DEPTH + 1; i++) s = {s, ".@\n"};
    run_frame("t4d", s, 1'b1, e);

    // Backpressure while the consumer holds off.
    run_frame("t5", "@.@\n", 1'b1, e);
    ack("t5", 5, 1'b1, e);

    // Reset mid-row discards the partial grid.
    push("@", 1'b0);
    push("@", 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("t6", "@\n\n", 1'b0, e);
    check("t6_rows_c",  GW'(bus.rows),  GW'(1));
    check("t6_cols_c",  GW'(bus.cols),  GW'(1));
    check("t6_rolls_c", GW'(bus.rolls), GW'(1));
    ack("t6", 0, 1'b0, e);

    // Random grids: clean, unterminated, CR/LF, leading blank line, ragged, corrupted.
    for (int n = 0; n < 40; n++) begin
      int r;
      int c;
      int v;
      int rag;
      v   = $urandom_range(0, 5);
      r   = (v == 3) ? $urandom_range(2, 4) : $urandom_range(1, 4);
      c   = $urandom_range(1, 6);
      rag = (v == 3) ? $urandom_range(1, r - 1) : -1;
      s   = (v == 5) ? "\n" : "";
      for (int i = 0; i < r; i++) begin
        int len;
        len = (i == rag) ? c + 1 : c;
        for (int j = 0; j < len; j++) s = {s, ($urandom_range(0, 1) != 0) ? "@" : "."};
        if (v == 5) s = {s, "\r"};
        if (i < r - 1 || v != 1) s = {s, "\n"};
      end
      if (v == 0) s = {s, "\n"};
      if (v == 4) s[$urandom_range(0, s.len() - 1)] = 8'h78;
      run_frame($sformatf("rnd%0d", n), s, 1'b1, e);
      if (e.kind == K_DONE) ack($sformatf("rnd%0d", n), $urandom_range(0, 3), 1'b0, e);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
